// File: rtl/acorn_init_sequencer.sv
// ACORN-128 init stream sequencer: key, IV, then key-loop steps, W steps per beat.
// Optional abort input when ACORN_INIT_ABORT_EN is defined.
// Ports:
//   clk, rst (async, active-low), start, key_in[127:0], iv_in[127:0]
//   m_valid/m_ready handshake, m_out/ca_out/cb_out [W-1:0], m_last
//   busy (sequence running), done (one-cycle pulse after last beat)
//   abort (ACORN_INIT_ABORT_EN only)
module acorn_init_sequencer #(
   parameter int W              = 1,
   parameter int NUM_LOOP_STEPS = 1536
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [127:0] iv_in,
`ifdef ACORN_INIT_ABORT_EN
   input  logic         abort,
`endif
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_out,
   output logic [W-1:0] ca_out,
   output logic [W-1:0] cb_out,
   output logic         m_last,
   output logic         busy,
   output logic         done
);

   localparam int TOTAL = 256 + NUM_LOOP_STEPS;
   localparam int CW    = $clog2(TOTAL) + 1;

   localparam logic [CW-1:0] STEP     = CW'(W);
   localparam logic [CW-1:0] KEY_LAST = CW'(128 - W);
   localparam logic [CW-1:0] IV_LAST  = CW'(256 - W);
   localparam logic [CW-1:0] LOOP_0   = CW'(256);
   localparam logic [CW-1:0] FIN_LAST = CW'(TOTAL - W);

   typedef enum logic [2:0] {
      IDLE,
      KEY,
      IV,
      LOOP,
      FIN
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [127:0]  key_q;
   logic [127:0]  iv_q;
   logic          xfer;
   logic          kill;
   logic [6:0]    idx;
   logic [W-1:0]  beat;

   assign xfer = m_valid & m_ready;

`ifdef ACORN_INIT_ABORT_EN
   assign kill = abort & busy;
`else
   assign kill = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Beats are W-aligned and W divides 128, so a beat never straddles
   // a phase boundary; cnt is the step index of beat bit 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         key_q <= '0;
         iv_q  <= '0;
      end else if (kill) begin
         cnt <= '0;
      end else if (state == IDLE && start) begin
         cnt   <= '0;
         key_q <= key_in;
         iv_q  <= iv_in;
      end else if (xfer) begin
         cnt <= cnt + STEP;
      end else if (state == FIN) begin
         cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      if (kill) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (start) state_nxt = KEY;
            KEY:  if (xfer && cnt == KEY_LAST) state_nxt = IV;
            IV:   if (xfer && cnt == IV_LAST) state_nxt = LOOP;
            LOOP: if (xfer && cnt == FIN_LAST) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Key-loop step s uses K_(s mod 128) since 256 is a multiple of 128;
   // step 256 alone carries K_0 inverted.
   always_comb begin
      busy    = (state == KEY) || (state == IV) || (state == LOOP);
      m_valid = busy;
      done    = (state == FIN);
      m_last  = (state == LOOP) && (cnt == FIN_LAST);
      idx     = cnt[6:0];
      if (state == IV) begin
         beat = iv_q[idx +: W];
      end else begin
         beat = key_q[idx +: W];
      end
      if (state == LOOP && cnt == LOOP_0) begin
         beat[0] = ~beat[0];
      end
      m_out  = busy ? beat : '0;
      ca_out = {W{busy}};
      cb_out = {W{busy}};
   end

endmodule

// File: tb/tb_acorn_init_sequencer.sv
// Scoreboard bench for acorn_init_sequencer at W=1, W=8 and W=32.
// Expected beats are queued at start; per-instance monitors pop on transfer.
module tb_acorn_init_sequencer;

   typedef struct packed {
      logic [127:0] m;
      logic         last;
   } beat_t;

   logic clk;
   logic rst;
   logic [127:0] key;
   logic [127:0] iv;
   logic st1, st8, st32;
   logic r1, r8, r32;
   logic abt8;
   logic tog;

   logic v1, l1, b1, d1;
   logic m1, ca1, cb1;
   logic v8, l8, b8, d8;
   logic [7:0] m8, ca8, cb8;
   logic v32, l32, b32, d32;
   logic [31:0] m32, ca32, cb32;

   beat_t q1[$];
   beat_t q8[$];
   beat_t q32[$];

   int checks = 0;
   int errors = 0;
   int n1, n8, n32;
   int ones1, pos1;
   bit d1p, d8p, d32p;
   bit h32;
   logic [31:0] hm32;
   logic hl32;
   logic [7:0] rec8[224];
   logic [31:0] rec32[2][56];
   int run32;

   acorn_init_sequencer #(.W(1)) u1 (
      .clk(clk), .rst(rst), .start(st1), .key_in(key), .iv_in(iv),
`ifdef ACORN_INIT_ABORT_EN
      .abort(1'b0),
`endif
      .m_valid(v1), .m_ready(r1), .m_out(m1), .ca_out(ca1),
      .cb_out(cb1), .m_last(l1), .busy(b1), .done(d1)
   );

   acorn_init_sequencer #(.W(8)) u8 (
      .clk(clk), .rst(rst), .start(st8), .key_in(key), .iv_in(iv),
`ifdef ACORN_INIT_ABORT_EN
      .abort(abt8),
`endif
      .m_valid(v8), .m_ready(r8), .m_out(m8), .ca_out(ca8),
      .cb_out(cb8), .m_last(l8), .busy(b8), .done(d8)
   );

   acorn_init_sequencer #(.W(32)) u32 (
      .clk(clk), .rst(rst), .start(st32), .key_in(key), .iv_in(iv),
`ifdef ACORN_INIT_ABORT_EN
      .abort(1'b0),
`endif
      .m_valid(v32), .m_ready(r32), .m_out(m32), .ca_out(ca32),
      .cb_out(cb32), .m_last(l32), .busy(b32), .done(d32)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] a,
                      input logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic model(input logic [127:0] k,
                                  input logic [127:0] v, input int s);
      if (s < 128) return k[s];
      if (s < 256) return v[s-128];
      return k[(s-256)%128] ^ (s == 256);
   endfunction

   task automatic push_run(input int w, input logic [127:0] k,
                           input logic [127:0] v);
      beat_t b;
      int nb;
      nb = 1792 / w;
      for (int i = 0; i < nb; i++) begin
         b.m = '0;
         for (int j = 0; j < w; j++) b.m[j] = model(k, v, i*w+j);
         b.last = (i == nb-1);
         case (w)
            1: q1.push_back(b);
            8: q8.push_back(b);
            default: q32.push_back(b);
         endcase
      end
   endtask

   function automatic int cnt_of(input int w);
      case (w)
         1: return n1;
         8: return n8;
         default: return n32;
      endcase
   endfunction

   function automatic bit pending(input int w);
      case (w)
         1: return q1.size() != 0 || d1p || b1;
         8: return q8.size() != 0 || d8p || b8;
         default: return q32.size() != 0 || d32p || b32;
      endcase
   endfunction

   task automatic go(input int w, input logic [127:0] k,
                     input logic [127:0] v);
      key = k;
      iv = v;
      push_run(w, k, v);
      case (w)
         1: begin n1 = 0; ones1 = 0; pos1 = -1; st1 = 1; end
         8: begin n8 = 0; st8 = 1; end
         default: begin n32 = 0; st32 = 1; end
      endcase
      @(posedge clk);
      #1;
      st1 = 0;
      st8 = 0;
      st32 = 0;
      case (w)
         1: chk("start_latency_w1", {v1, b1}, 2'b11);
         8: chk("start_latency_w8", {v8, b8}, 2'b11);
         default: chk("start_latency_w32", {v32, b32}, 2'b11);
      endcase
   endtask

   task automatic run_wait(input int w);
      int c;
      c = 0;
      while (pending(w) && c < 8000) begin
         @(posedge clk);
         c++;
      end
      #1;
      if (c >= 8000) fail("run_timeout");
   endtask

   task automatic wait_n(input int w, input int tgt);
      int c;
      c = 0;
      while (cnt_of(w) < tgt && c < 8000) begin
         @(posedge clk);
         c++;
      end
      #1;
      if (c >= 8000) fail("beat_wait_timeout");
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         if (d1p) begin
            chk("w1_done", {d1, v1, b1}, 3'b100);
            d1p = 0;
         end else if (d1) begin
            fail("w1_spurious_done");
         end
         if (v1 && r1) begin
            if (q1.size() == 0) begin
               fail("w1_extra_beat");
            end else begin
               e = q1.pop_front();
               chk("w1_m", m1, e.m);
               chk("w1_cacb", {ca1, cb1}, 2'b11);
               chk("w1_last", l1, e.last);
               if (m1) begin ones1++; pos1 = n1; end
               n1++;
               if (e.last) d1p = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         if (d8p) begin
            chk("w8_done", {d8, v8, b8}, 3'b100);
            d8p = 0;
         end else if (d8) begin
            fail("w8_spurious_done");
         end
         if (v8 && r8 && !abt8) begin
            if (q8.size() == 0) begin
               fail("w8_extra_beat");
            end else begin
               e = q8.pop_front();
               chk("w8_m", m8, e.m);
               chk("w8_cacb", {ca8, cb8}, 16'hFFFF);
               chk("w8_last", l8, e.last);
               if (n8 < 224) rec8[n8] = m8;
               n8++;
               if (e.last) d8p = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         if (d32p) begin
            chk("w32_done", {d32, v32, b32}, 3'b100);
            d32p = 0;
         end else if (d32) begin
            fail("w32_spurious_done");
         end
         if (h32) begin
            chk("w32_hold_m", m32, hm32);
            chk("w32_hold_last", l32, hl32);
            chk("w32_hold_valid", v32, 1);
            h32 = 0;
         end
         if (v32 && !r32) begin
            h32 = 1;
            hm32 = m32;
            hl32 = l32;
         end
         if (v32 && r32) begin
            if (q32.size() == 0) begin
               fail("w32_extra_beat");
            end else begin
               e = q32.pop_front();
               chk("w32_m", m32, e.m);
               chk("w32_cacb", {ca32, cb32}, {64{1'b1}});
               chk("w32_last", l32, e.last);
               if (n32 < 56) rec32[run32][n32] = m32;
               n32++;
               if (e.last) d32p = 1;
            end
         end
      end
   end

   initial begin
      r32 = 1;
      forever begin
         @(posedge clk);
         #1;
         r32 = tog ? ~r32 : 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ka, ia;
      rst = 0;
      key = '0;
      iv = '0;
      st1 = 0; st8 = 0; st32 = 0;
      r1 = 1; r8 = 1;
      abt8 = 0;
      tog = 0;
      run32 = 0;
      n1 = 0; n8 = 0; n32 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_w1", {v1, m1, ca1, cb1, l1, b1, d1}, 0);
      chk("reset_w8", {v8, m8, ca8, cb8, l8, b8, d8}, 0);
      chk("reset_w32", {v32, m32, ca32, cb32, l32, b32, d32}, 0);
      rst = 1;
      @(posedge clk);
      #1;

      go(1, '0, '0);
      run_wait(1);
      chk("w1_beats", n1, 1792);
      chk("w1_ones", ones1, 1);
      chk("w1_one_pos", pos1, 256);

      go(8, 128'h1, 128'hFF << 8);
      wait_n(8, 10);
      key = ~128'h0;
      iv = '0;
      st8 = 1;
      @(posedge clk);
      #1;
      st8 = 0;
      chk("restart_ignored_busy", b8, 1);
      run_wait(8);
      chk("w8_beats", n8, 224);
      chk("w8_beat0", rec8[0], 8'h01);
      chk("w8_beat16", rec8[16], 8'h00);
      chk("w8_beat17", rec8[17], 8'hFF);
      chk("w8_beat32", rec8[32], 8'h00);
      chk("w8_beat48", rec8[48], 8'h01);

      ka = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      ia = 128'hA5A5_0F0F_3C3C_9696_C3C3_5A5A_F0F0_1234;
      run32 = 0;
      go(32, ka, ia);
      run_wait(32);
      chk("w32_beats_ready", n32, 56);
      run32 = 1;
      tog = 1;
      go(32, ka, ia);
      run_wait(32);
      tog = 0;
      chk("w32_beats_toggle", n32, 56);
      for (int i = 0; i < 56; i++) chk("w32_same_stream", rec32[1][i], rec32[0][i]);

      go(1, ka, ia);
      wait_n(1, 500);
      rst = 0;
      #1;
      chk("async_rst_w1", {v1, m1, ca1, cb1, l1, b1, d1}, 0);
      q1.delete();
      d1p = 0;
      @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      go(1, ka, ia);
      run_wait(1);
      chk("w1_beats_after_rst", n1, 1792);

`ifdef ACORN_INIT_ABORT_EN
      go(8, ka, ia);
      wait_n(8, 100);
      abt8 = 1;
      @(posedge clk);
      #1;
      abt8 = 0;
      q8.delete();
      chk("abort_idle", {v8, b8, d8}, 3'b000);
      repeat (3) @(posedge clk);
      #1;
      go(8, ka, ia);
      run_wait(8);
      chk("w8_beats_after_abort", n8, 224);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
